rr_arbiter_8: RTL



---
 rtl/rr_arbiter_8.sv | 135 +++++++++++++
 1 files changed

// File: rtl/rr_arbiter_8.sv
// ============================================================================
// rr_arbiter_8 : 8-way round-robin arbiter, registered one-hot grant, bounded
//                hold with forced rotation. Optional macro: RR_ARB_LOCK_EN.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
`ifdef RR_ARB_LOCK_EN
  input  logic       lock,
`endif
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       gnt_new
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam bit         PREEMPT_EN = (MAX_HOLD != 0);
  // With preemption disabled the counter still needs a ceiling; it is unobservable.
  localparam logic [7:0] HOLD_SAT   = (MAX_HOLD == 0) ? 8'd255 : 8'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] idx_q, idx_d;
  logic       valid_q, valid_d;
  logic       new_q, new_d;
  logic [2:0] last_q, last_d;
  logic [7:0] hold_q, hold_d;

  logic [3:0] w_win_last;
  logic [3:0] w_win_cur;
  logic [7:0] w_other;
  logic       w_lock;

  // Returns {found, index}; scanning offsets downward lets the nearest one win.
  function automatic logic [3:0] search(input logic [2:0] base, input logic [7:0] r);
    logic [3:0] res;
    logic [2:0] c;
    res = 4'b0000;
    for (int k = 8; k >= 1; k--) begin
      c = base + 3'(k);
      if (r[c]) res = {1'b1, c};
    end
    return res;
  endfunction

`ifdef RR_ARB_LOCK_EN
  assign w_lock = lock;
`else
  assign w_lock = 1'b0;
`endif

  assign w_win_last = search(last_q, req);
  assign w_win_cur  = search(idx_q, req);
  assign w_other    = req & ~(8'b1 << idx_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    new_d   = 1'b0;
    last_d  = last_q;
    hold_d  = hold_q;

    if (state_q == S_IDLE) begin
      if (w_win_last[3]) begin
        state_d = S_GRANT;
        idx_d   = w_win_last[2:0];
        valid_d = 1'b1;
        new_d   = 1'b1;
        hold_d  = 8'd0;
      end
    end else begin
      if (!req[idx_q]) begin
        last_d = idx_q;
        if (w_win_cur[3]) begin
          idx_d  = w_win_cur[2:0];
          new_d  = 1'b1;
          hold_d = 8'd0;
        end else begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      end else if (PREEMPT_EN && (hold_q == HOLD_SAT) && (|w_other) && !w_lock) begin
        // Holder's own bit is still set, so the search lands on another requester.
        last_d = idx_q;
        idx_d  = w_win_cur[2:0];
        new_d  = 1'b1;
        hold_d = 8'd0;
      end else if (hold_q != HOLD_SAT) begin
        hold_d = hold_q + 8'd1;
      end
    end

    gnt_d = valid_d ? (8'b1 << idx_d) : 8'h00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= 8'h00;
      idx_q   <= 3'd0;
      valid_q <= 1'b0;
      new_q   <= 1'b0;
      last_q  <= 3'd7;
      hold_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      new_q   <= new_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;
  assign gnt_new   = new_q;

endmodule

`default_nettype wire
